// File: rtl/img_pkg.sv
// Shared image geometry, datapath widths and the writeback FSM state type
// for the processed-image memory path.
package img_pkg;
  localparam int IMG_W      = 390;
  localparam int IMG_H      = 390;
  localparam int NUM_PIXELS = IMG_W * IMG_H;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 32;
  // Pixel counters are sized to hold one full frame (152100 < 2**18).
  localparam int CNT_W      = 18;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wb_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for pixel bytes. The pointers are one bit wider
// than the index, so a full FIFO and an empty FIFO have different pointer values.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pixel_writeback_unit.sv
// Buffers the processed pixel stream and turns it into sequential byte writes
// (WE/wA/WD) into the image memory, reporting completion after one frame.
module pixel_writeback_unit
  import img_pkg::*;
#(
  parameter int NUM_PIXELS = img_pkg::NUM_PIXELS,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = img_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] wA,
  output logic [PIX_W-1:0]  WD,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pix_count,
  output wb_state_t         state_dbg
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIXELS);

  wb_state_t         state;
  wb_state_t         state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_dout;
  logic              push;
  logic              pop;

  // Handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both high. pix_ready never looks at pix_valid, and upstream
  // must hold pix_data stable while pix_valid is high and pix_ready is low.
  always_comb begin
    pix_ready = (state == RUN) && !fifo_full && (acc_cnt < LAST);
    push      = pix_valid && pix_ready;
    pop       = ((state == RUN) || (state == FLUSH)) && !fifo_empty;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (acc_cnt == LAST) state_nxt = FLUSH;
      FLUSH:   if (fifo_empty && (wr_cnt == LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      base_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      WE      <= 1'b0;
      wA      <= '0;
      WD      <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        base_q  <= base_addr;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end
      if (push) acc_cnt <= acc_cnt + CNT_W'(1);
      // wA/WD keep their last values between writes.
      WE <= pop;
      if (pop) begin
        wA     <= base_q + ADDR_W'(wr_cnt);
        WD     <= fifo_dout;
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pix_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign pix_count = wr_cnt;
  assign state_dbg = state;
endmodule

// File: tb/tb_pixel_writeback_unit.sv
// Directed bench for pixel_writeback_unit with a six-pixel frame and a
// four-entry FIFO; expected writes are queued on accept and checked on WE.
module tb_pixel_writeback_unit;
  import img_pkg::*;

  localparam int NPIX = 6;

  logic              CLK;
  logic              reset;
  logic              start;
  logic [31:0]       base_addr;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
  logic              WE;
  logic [31:0]       wA;
  logic [7:0]        WD;
  logic              busy;
  logic              done;
  logic [17:0]       pix_count;
  wb_state_t         state_dbg;

  logic [39:0] exp_q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          done_cnt;
  int          first_acc;
  int          first_wr;
  int          last_wr;
  int          sent;
  bit          acc_flag;
  bit          start_expect;
  logic [31:0] fbase;
  logic [31:0] idx;

  pixel_writeback_unit #(.NUM_PIXELS(NPIX), .FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .WE        (WE),
    .wA        (wA),
    .WD        (WD),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count),
    .state_dbg (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge (scoreboard pop, then push), return 1 after the rising edge.
  task automatic step();
    logic [39:0] e;
    @(negedge CLK);
    cyc++;
    acc_flag = 1'b0;
    if (WE) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'(wA), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wA", 64'(wA), 64'(e[39:8]));
        chk("WD", 64'(WD), 64'(e[7:0]));
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end
    if (done) done_cnt++;
    if (reset) begin
      exp_q.delete();
      idx = '0;
    end else begin
      if (start && start_expect) begin
        fbase = base_addr;
        idx   = '0;
      end
      if (pix_valid && pix_ready) begin
        exp_q.push_back({fbase + idx, pix_data});
        idx = idx + 32'd1;
        acc_flag = 1'b1;
        if (first_acc < 0) first_acc = cyc;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_WE"}, 64'(WE), 0);
    chk({tag, "_wA"}, 64'(wA), 0);
    chk({tag, "_WD"}, 64'(WD), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pix_count"}, 64'(pix_count), 0);
    chk({tag, "_pix_ready"}, 64'(pix_ready), 0);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt != d0) break;
      step();
    end
    chk({tag, "_done_seen"}, 64'(done_cnt - d0), 1);
    repeat (3) step();
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 1);
    chk({tag, "_pix_count"}, 64'(pix_count), NPIX);
    chk({tag, "_busy_after"}, 64'(busy), 0);
    chk({tag, "_WE_after"}, 64'(WE), 0);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
  endtask

  // Sends one frame; gaps drops valid every other cycle, busy_start re-pulses start mid-frame.
  task automatic run_frame(input string tag, input logic [31:0] base, input logic [7:0] d0,
                           input bit gaps, input bit busy_start);
    bit restarted;
    restarted = 1'b0;
    sent = 0;
    first_acc = -1;
    first_wr = -1;
    base_addr = base;
    start = 1'b1;
    start_expect = 1'b1;
    step();
    start = 1'b0;
    start_expect = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 1);
    for (int i = 0; i < 60 && sent < NPIX; i++) begin
      pix_valid = gaps ? (i % 2 == 0) : 1'b1;
      pix_data = d0 + 8'(sent);
      if (busy_start && !restarted && sent == 2) begin
        start = 1'b1;
        base_addr = 32'h900;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (acc_flag) sent++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_sent"}, 64'(sent), NPIX);
    wait_done(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    done_cnt = 0;
    first_acc = -1;
    first_wr = -1;
    last_wr = -1;
    sent = 0;
    acc_flag = 1'b0;
    start_expect = 1'b0;
    fbase = '0;
    idx = '0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    pix_valid = 1'b0;
    pix_data = '0;

    step();
    step();
    reset = 1'b0;
    check_zero("reset");

    pix_valid = 1'b1;
    pix_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_WE", 64'(WE), 0);
      chk("idle_busy", 64'(busy), 0);
      chk("idle_done", 64'(done), 0);
      chk("idle_pix_ready", 64'(pix_ready), 0);
    end
    pix_valid = 1'b0;
    chk("idle_no_accept", 64'(exp_q.size()), 0);

    run_frame("stream", 32'h100, 8'h10, 1'b0, 1'b0);
    chk("stream_latency", 64'(first_wr - first_acc), 2);
    chk("stream_back_to_back", 64'(last_wr - first_wr), NPIX - 1);

    run_frame("gaps", 32'h0, 8'h20, 1'b1, 1'b0);

    run_frame("restart_ignored", 32'h500, 8'h30, 1'b0, 1'b1);

    base_addr = 32'h300;
    start = 1'b1;
    start_expect = 1'b1;
    step();
    start = 1'b0;
    start_expect = 1'b0;
    sent = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < 30 && sent < 3; i++) begin
      pix_data = 8'h40 + 8'(sent);
      step();
      if (acc_flag) sent++;
    end
    chk("abort_sent", 64'(sent), 3);
    pix_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("abort");
    step();
    chk("abort_quiet_WE", 64'(WE), 0);
    chk("abort_quiet_count", 64'(pix_count), 0);
    run_frame("after_abort", 32'h200, 8'h50, 1'b0, 1'b0);

    run_frame("wrap", 32'hFFFF_FFFE, 8'h60, 1'b0, 1'b0);
    chk("wrap_last_wA", 64'(wA), 64'h3);

    chk("final_queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
